mem_stage_pipe: RTL and testbench

//   Parametrised memory stage for the 5-stage pipeline: data-memory access plus branch/jump resolution.

---
 rtl/mem_stage_pipe.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// Pipeline MEM stage: data memory with configurable read latency and a stall/valid
// handshake, plus branch/jump resolution feeding pc_src.
module mem_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int BR_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              mem_wr,
  input  logic              mem_rd,
  input  logic              flush,
  input  logic [2:0]        flags,
  input  logic [2:0]        branch_op,
  input  logic              saw_br,
  input  logic              saw_j,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              stall,
  output logic              pc_src,
  output logic              err
);

  localparam int CNT_W = 4;

  localparam logic [2:0] BNEQ    = 3'd0;
  localparam logic [2:0] BEQ     = 3'd1;
  localparam logic [2:0] BGT     = 3'd2;
  localparam logic [2:0] BLT     = 3'd3;
  localparam logic [2:0] BGTE    = 3'd4;
  localparam logic [2:0] BLTE    = 3'd5;
  localparam logic [2:0] BOVFL   = 3'd6;
  localparam logic [2:0] BUNCOND = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic              load_data;
  logic [ADDR_W-1:0] load_addr;

  // NOTE: the data array has no reset; clearing 2**ADDR_W words is neither needed nor cheap.
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  // NOTE: sequential blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[mem_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    err_d     = err_q;
    wr_en     = 1'b0;
    load_data = 1'b0;
    load_addr = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        wr_en = mem_wr & ~flush;
        // A simultaneous load and store keeps the store and drops the load.
        if (mem_rd && mem_wr) begin
          err_d = 1'b1;
        end else if (mem_rd) begin
          addr_d = mem_addr;
          cnt_d  = CNT_W'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            state_d   = ST_DONE;
            load_data = 1'b1;
            load_addr = mem_addr;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = ST_DONE;
            load_data = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (load_data) begin
      rd_data_d = mem_q[load_addr];
    end
  end

  // Stall is combinational so the hazard unit freezes upstream in the accept cycle itself.
  always_comb begin
    rd_valid = (state_q == ST_DONE) && !flush;
    stall    = rst_n && (((state_q == ST_IDLE) && mem_rd && !mem_wr) ||
                         ((state_q == ST_BUSY) && !flush));
  end

  assign rd_data = rd_data_q;
  assign err     = err_q;

  logic flag_n, flag_z, flag_v;
  logic cmp;
  logic pc_src_d;

  always_comb begin
    flag_n = flags[2];
    flag_z = flags[1];
    flag_v = flags[0];
    cmp    = 1'b0;
    case (branch_op)
      BNEQ:    cmp = !flag_z;
      BEQ:     cmp = flag_z;
      BGT:     cmp = !flag_z && !flag_n;
      BLT:     cmp = flag_n;
      BGTE:    cmp = !flag_n;
      BLTE:    cmp = flag_n || flag_z;
      BOVFL:   cmp = flag_v;
      BUNCOND: cmp = 1'b1;
      default: cmp = 1'b0;
    endcase
    pc_src_d = (saw_br && cmp) || saw_j;
  end

  if (BR_REG != 0) begin : g_pc_reg
    logic pc_src_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pc_src_q <= 1'b0;
      end else begin
        pc_src_q <= pc_src_d;
      end
    end
    assign pc_src = pc_src_q;
  end else begin : g_pc_comb
    assign pc_src = pc_src_d;
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe: directed handshake/flush/error/reset steps plus
// randomized load/store traffic and branch resolution checked against a behavioural model.
module tb_mem_stage_pipe;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr, wr_data;
  logic        mem_wr, mem_rd, flush;
  logic [2:0]  flags, branch_op;
  logic        saw_br, saw_j;

  logic [15:0] rd_data, r_rd_data;
  logic        rd_valid, stall, pc_src, err;
  logic        r_rd_valid, r_stall, r_pc_src, r_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] ref_mem [logic [15:0]];

  mem_stage_pipe #(.DATA_W(16), .ADDR_W(16), .RD_LAT(RD_LAT), .BR_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .wr_data(wr_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .flush(flush), .flags(flags),
    .branch_op(branch_op), .saw_br(saw_br), .saw_j(saw_j),
    .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .pc_src(pc_src), .err(err)
  );

  mem_stage_pipe #(.DATA_W(16), .ADDR_W(16), .RD_LAT(RD_LAT), .BR_REG(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .wr_data(wr_data),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .flush(flush), .flags(flags),
    .branch_op(branch_op), .saw_br(saw_br), .saw_j(saw_j),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .stall(r_stall), .pc_src(r_pc_src), .err(r_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Branch condition taken straight from the condition-code table.
  function automatic bit ref_taken(input int op, input int f, input bit br, input bit j);
    bit n, z, v, c;
    n = f[2]; z = f[1]; v = f[0];
    case (op)
      0: c = !z;
      1: c = z;
      2: c = !z && !n;
      3: c = n;
      4: c = !n;
      5: c = n || z;
      6: c = v;
      7: c = 1'b1;
      default: c = 1'b0;
    endcase
    return (br && c) || j;
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit fl);
    mem_addr = a; wr_data = d; mem_wr = 1'b1; flush = fl;
    mid();
    check("wr_no_stall", stall, 1'b0);
    tick();
    if (!fl) ref_mem[a] = d;
    mem_wr = 1'b0; flush = 1'b0;
  endtask

  // Load spanning RD_LAT stall cycles then a one-cycle valid; mem_rd stays high in DONE.
  task automatic do_read(input logic [15:0] a, output int vcyc);
    mem_addr = a; mem_rd = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      mid();
      check("rd_stall", stall, 1'b1);
      check("rd_not_valid", rd_valid, 1'b0);
      tick();
    end
    mid();
    check("rd_valid", rd_valid, 1'b1);
    check("rd_done_stall", stall, 1'b0);
    check("rd_data", rd_data, ref_mem.exists(a) ? ref_mem[a] : 16'hxxxx);
    vcyc = cyc;
    tick();
    mem_rd = 1'b0;
  endtask

  initial begin
    int v1, v2, dummy;
    bit prev_exp, exp;
    logic [15:0] a, d;

    rst_n = 1'b0; mem_addr = 16'h0; wr_data = 16'h0; mem_wr = 1'b0; flush = 1'b0;
    flags = 3'b0; branch_op = 3'd0; saw_br = 1'b0; saw_j = 1'b1; mem_rd = 1'b1;

    // Reset state, with a pending load that must not stall.
    tick(); tick();
    check("rst_stall", stall, 1'b0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_rd_data", rd_data, 16'h0);
    check("rst_err", err, 1'b0);
    check("rst_pc_reg", r_pc_src, 1'b0);
    check("rst_pc_comb_jump", pc_src, 1'b1);
    mem_rd = 1'b0; saw_j = 1'b0;
    mid();
    rst_n = 1'b1;
    tick();

    // First load after a store.
    do_write(16'h0010, 16'hBEEF, 1'b0);
    do_write(16'h0011, 16'h1234, 1'b0);
    do_read(16'h0010, dummy);
    mid();
    check("hold_valid", rd_valid, 1'b0);
    check("hold_data", rd_data, 16'hBEEF);
    tick();

    // Back-to-back loads.
    do_read(16'h0010, v1);
    do_read(16'h0011, v2);
    check("b2b_gap", v2 - v1, 3);

    // Flush in BUSY.
    mem_addr = 16'h0011; mem_rd = 1'b1;
    mid();
    check("fl_accept_stall", stall, 1'b1);
    tick();
    flush = 1'b1; mem_rd = 1'b0;
    mid();
    check("fl_busy_stall", stall, 1'b0);
    check("fl_busy_valid", rd_valid, 1'b0);
    tick();
    flush = 1'b0;
    mid();
    check("fl_after_valid", rd_valid, 1'b0);
    check("fl_after_stall", stall, 1'b0);
    tick();
    do_read(16'h0010, dummy);

    // Flush in DONE masks the valid pulse.
    mem_addr = 16'h0011; mem_rd = 1'b1;
    tick(); tick();
    flush = 1'b1; mem_rd = 1'b0;
    mid();
    check("fl_done_valid", rd_valid, 1'b0);
    check("fl_done_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    mid();
    check("fl_done_after", rd_valid, 1'b0);
    tick();

    // Flush in IDLE suppresses a store.
    do_write(16'h0030, 16'h1111, 1'b0);
    do_write(16'h0030, 16'hAAAA, 1'b1);
    do_read(16'h0030, dummy);

    // Simultaneous load and store.
    mem_addr = 16'h0020; wr_data = 16'h5555; mem_rd = 1'b1; mem_wr = 1'b1;
    mid();
    check("rw_stall", stall, 1'b0);
    check("rw_valid", rd_valid, 1'b0);
    tick();
    ref_mem[16'h0020] = 16'h5555;
    mem_rd = 1'b0; mem_wr = 1'b0;
    mid();
    check("rw_err", err, 1'b1);
    check("rw_no_valid", rd_valid, 1'b0);
    tick(); tick(); tick();
    check("rw_err_sticky", err, 1'b1);
    do_read(16'h0020, dummy);

    // Randomized load/store traffic over a small address pool.
    for (int i = 0; i < 8; i++) do_write(16'h0100 + 16'(i), 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      a = 16'h0100 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0) begin
        d = 16'($urandom);
        do_write(a, d, 1'b0);
      end else begin
        do_read(a, dummy);
      end
    end
    check("err_still_set", err, 1'b1);

    // Branch sweep; the registered instance lags by one cycle.
    prev_exp = 1'b0;
    for (int op = 0; op < 8; op++) begin
      for (int f = 0; f < 8; f++) begin
        branch_op = 3'(op); flags = 3'(f); saw_br = 1'b1; saw_j = 1'b0;
        exp = ref_taken(op, f, 1'b1, 1'b0);
        mid();
        check($sformatf("br_op%0d_f%0d", op, f), pc_src, exp);
        check("br_reg_lag", r_pc_src, prev_exp);
        prev_exp = exp;
        tick();
      end
    end
    for (int i = 0; i < 32; i++) begin
      branch_op = 3'($urandom); flags = 3'($urandom);
      saw_br = 1'($urandom); saw_j = 1'($urandom);
      exp = ref_taken(int'(branch_op), int'(flags), saw_br, saw_j);
      mid();
      check("br_rand", pc_src, exp);
      check("br_rand_reg", r_pc_src, prev_exp);
      prev_exp = exp;
      tick();
    end
    saw_br = 1'b0; saw_j = 1'b0;
    mid();
    check("br_none", pc_src, 1'b0);
    tick();

    // Reset in the middle of a load.
    mem_addr = 16'h0011; mem_rd = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check("rb_stall", stall, 1'b0);
    check("rb_valid", rd_valid, 1'b0);
    check("rb_rd_data", rd_data, 16'h0);
    check("rb_err", err, 1'b0);
    mem_rd = 1'b0;
    tick();
    mid();
    rst_n = 1'b1;
    tick();
    mid();
    check("rb_release_valid", rd_valid, 1'b0);
    check("rb_release_stall", stall, 1'b0);
    tick();
    do_read(16'h0011, dummy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
